decode_stage: RTL and testbench

//  Registered RV32I decode stage between fetch and execute. Decodes all RV32I

---
 rtl/decode_stage.sv | 276 +++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with a 2-entry skid buffer
// (output register OUT plus skid register SKD) and valid/ready on both sides.
// Optional feature macro: DECODE_RV32M_EN decodes RV32M (OP, funct7=0000001)
// as legal muldiv instructions; without it those encodings are illegal.
module decode_stage #(
    parameter int XLEN    = 32,
    parameter int PC_W    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [31:0]        instr_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [PC_W-1:0]    pc_o,
    output logic [6:0]         opcode_o,
    output logic [2:0]         funct3_o,
    output logic [4:0]         rd_o,
    output logic [4:0]         rs1_o,
    output logic [4:0]         rs2_o,
    output logic [XLEN-1:0]    imm_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               alu_src_imm_o,
    output logic               reg_write_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               mem_to_reg_o,
    output logic               branch_o,
    output logic               jump_o,
    output logic               jalr_o,
    output logic               muldiv_o,
    output logic               illegal_o
);

    localparam logic [ALUOP_W-1:0] ALU_ADD    = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB    = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SLL    = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_SLT    = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SLTU   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_XOR    = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SRL    = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SRA    = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_OR     = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_AND    = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_PASS_B = ALUOP_W'(10);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [6:0]         opcode;
        logic [2:0]         funct3;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [XLEN-1:0]    imm;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src_imm;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               branch;
        logic               jump;
        logic               jalr;
        logic               muldiv;
        logic               illegal;
    } bundle_t;

    bundle_t         dec;
    bundle_t         out_q;
    bundle_t         skd_q;
    logic            out_valid_q;
    logic            skd_valid_q;
    logic            illegal;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    function automatic logic [ALUOP_W-1:0] alu_from_f3(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_i  = XLEN'($signed(instr_i[31:20]));
    assign imm_s  = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
    assign imm_b  = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({instr_i[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));

    // Decode the incoming word into a bundle; illegal encodings still pass but lose their write enables.
    always_comb begin
        dec        = '0;
        illegal    = 1'b0;
        dec.pc     = pc_i;
        dec.opcode = opcode;
        dec.funct3 = funct3;
        dec.rd     = instr_i[11:7];
        dec.rs1    = instr_i[19:15];
        dec.rs2    = instr_i[24:20];
        case (opcode)
            OPC_LUI: begin
                dec.alu_op      = ALU_PASS_B;
                dec.imm         = imm_u;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm         = imm_u;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_JAL: begin
                dec.jump      = 1'b1;
                dec.imm       = imm_j;
                dec.reg_write = 1'b1;
            end
            OPC_JALR: begin
                dec.jalr        = 1'b1;
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
                illegal         = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                dec.imm    = imm_b;
                case (funct3)
                    3'b000, 3'b001: dec.alu_op = ALU_SUB;
                    3'b100, 3'b101: dec.alu_op = ALU_SLT;
                    3'b110, 3'b111: dec.alu_op = ALU_SLTU;
                    default:        illegal    = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.mem_read    = 1'b1;
                dec.mem_to_reg  = 1'b1;
                dec.reg_write   = 1'b1;
                illegal         = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec.imm         = imm_s;
                dec.alu_src_imm = 1'b1;
                dec.mem_write   = 1'b1;
                illegal         = (funct3 > 3'b010);
            end
            OPC_OPIMM: begin
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
                dec.alu_op      = alu_from_f3(funct3);
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0100000) begin
                        dec.alu_op = ALU_SRA;
                    end else if (funct7 != 7'b0000000) begin
                        illegal = 1'b1;
                    end
                end
            end
            OPC_OP: begin
                dec.reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    dec.alu_op = alu_from_f3(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.alu_op = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec.alu_op = ALU_SRA;
                end else if (funct7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
                    dec.muldiv = 1'b1;
                    dec.alu_op = ALU_ADD;
`else
                    illegal = 1'b1;
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_FENCE: begin
                illegal = (funct3 != 3'b000);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (illegal) begin
            dec.illegal   = 1'b1;
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.alu_op    = ALU_ADD;
        end
    end

    // OUT/SKD skid buffer: drain OUT, refill from SKD, then park a new word in OUT or SKD; flush clears both.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            skd_valid_q <= 1'b0;
            out_q       <= '0;
            skd_q       <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
            skd_valid_q <= 1'b0;
        end else if (!out_valid_q || out_ready_i) begin
            if (skd_valid_q) begin
                out_q       <= skd_q;
                out_valid_q <= 1'b1;
                skd_valid_q <= 1'b0;
            end else if (in_valid_i) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_valid_i && !skd_valid_q) begin
            skd_q       <= dec;
            skd_valid_q <= 1'b1;
        end
    end

    assign in_ready_o    = !skd_valid_q;
    assign out_valid_o   = out_valid_q;
    assign pc_o          = out_q.pc;
    assign opcode_o      = out_q.opcode;
    assign funct3_o      = out_q.funct3;
    assign rd_o          = out_q.rd;
    assign rs1_o         = out_q.rs1;
    assign rs2_o         = out_q.rs2;
    assign imm_o         = out_q.imm;
    assign alu_op_o      = out_q.alu_op;
    assign alu_src_imm_o = out_q.alu_src_imm;
    assign reg_write_o   = out_q.reg_write;
    assign mem_read_o    = out_q.mem_read;
    assign mem_write_o   = out_q.mem_write;
    assign mem_to_reg_o  = out_q.mem_to_reg;
    assign branch_o      = out_q.branch;
    assign jump_o        = out_q.jump;
    assign jalr_o        = out_q.jalr;
    assign muldiv_o      = out_q.muldiv;
    assign illegal_o     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage with a queue-based reference model.
// Follows DECODE_RV32M_EN the same way the design does.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  aluOp;
        logic        srcImm;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        memToReg;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        muldiv;
        logic        illegal;
    } bundle_t;

`ifdef DECODE_RV32M_EN
    localparam bit HAS_M = 1'b1;
`else
    localparam bit HAS_M = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] pcO;
    logic [6:0]  opcodeO;
    logic [2:0]  funct3O;
    logic [4:0]  rdO, rs1O, rs2O;
    logic [31:0] immO;
    logic [3:0]  aluOpO;
    logic        srcImmO, regWriteO, memReadO, memWriteO, memToRegO;
    logic        branchO, jumpO, jalrO, muldivO, illegalO;
    bundle_t     dutB;

    int          checks = 0;
    int          failures = 0;
    bit          sawFlushed = 1'b0;
    bit          modelAccept;
    bundle_t     modelQ[$];
    int          aluFromF3[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic [31:0] streamVec[20] = '{
        32'h123450B7, 32'h00001117, 32'h008000EF, 32'h000080E7, 32'h00209463,
        32'h0020C463, 32'h0020E463, 32'h0040A183, 32'h0030A223, 32'h40208133,
        32'h4020D133, 32'h0020F133, 32'h00309093, 32'h4030D093, 32'h0000000F,
        32'h00000073, 32'h0040B183, 32'h0000A0E7, 32'h02309093, 32'h00208132};

    decode_stage dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(inValid), .in_ready_o(inReady), .instr_i(instr), .pc_i(pc),
        .out_valid_o(outValid), .out_ready_i(outReady), .pc_o(pcO),
        .opcode_o(opcodeO), .funct3_o(funct3O), .rd_o(rdO), .rs1_o(rs1O), .rs2_o(rs2O),
        .imm_o(immO), .alu_op_o(aluOpO), .alu_src_imm_o(srcImmO),
        .reg_write_o(regWriteO), .mem_read_o(memReadO), .mem_write_o(memWriteO),
        .mem_to_reg_o(memToRegO), .branch_o(branchO), .jump_o(jumpO), .jalr_o(jalrO),
        .muldiv_o(muldivO), .illegal_o(illegalO)
    );

    assign dutB = {pcO, opcodeO, funct3O, rdO, rs1O, rs2O, immO, aluOpO, srcImmO,
                   regWriteO, memReadO, memWriteO, memToRegO, branchO, jumpO, jalrO,
                   muldivO, illegalO};

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Reference decode: build what the bundle must be from the instruction's meaning.
    function automatic bundle_t modelDecode(logic [31:0] w, logic [31:0] p);
        bundle_t    b;
        logic [6:0] f7;
        logic [2:0] f3;
        int         sw, sgn, iImm, sImm, bImm, uImm, jImm;
        bit         ok;
        b = '0;
        f7 = w[31:25];
        f3 = w[14:12];
        b.pc = p;
        b.opcode = w[6:0];
        b.funct3 = f3;
        b.rd = w[11:7];
        b.rs1 = w[19:15];
        b.rs2 = w[24:20];
        sw = int'(w);
        sgn = sw >>> 31;
        iImm = sw >>> 20;
        sImm = ((sw >>> 20) & ~31) | int'(w[11:7]);
        bImm = (sgn << 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1);
        uImm = sw & ~32'hFFF;
        jImm = (sgn << 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11) | (int'(w[30:21]) << 1);
        ok = 1'b1;
        case (w[6:0])
            7'h37: begin b.aluOp = 4'd10; b.imm = uImm; b.srcImm = 1; b.regWrite = 1; end
            7'h17: begin b.imm = uImm; b.srcImm = 1; b.regWrite = 1; end
            7'h6F: begin b.jump = 1; b.imm = jImm; b.regWrite = 1; end
            7'h67: begin b.jalr = 1; b.imm = iImm; b.srcImm = 1; b.regWrite = 1; ok = (f3 == 0); end
            7'h63: begin
                b.branch = 1; b.imm = bImm;
                ok = (f3 != 2) && (f3 != 3);
                b.aluOp = (f3 < 2) ? 4'd1 : ((f3 < 6) ? 4'd3 : 4'd4);
            end
            7'h03: begin
                b.imm = iImm; b.srcImm = 1; b.memRead = 1; b.memToReg = 1; b.regWrite = 1;
                ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
            end
            7'h23: begin b.imm = sImm; b.srcImm = 1; b.memWrite = 1; ok = (f3 < 3); end
            7'h13: begin
                b.imm = iImm; b.srcImm = 1; b.regWrite = 1;
                b.aluOp = 4'(aluFromF3[f3] + ((f3 == 5 && f7 == 7'h20) ? 1 : 0));
                if (f3 == 1) ok = (f7 == 0);
                else if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
            end
            7'h33: begin
                b.regWrite = 1;
                if (f7 == 7'h01) begin
                    ok = HAS_M;
                    b.muldiv = HAS_M;
                end else begin
                    ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                    b.aluOp = 4'(aluFromF3[f3] + int'(f7[5]));
                end
            end
            7'h0F: ok = (f3 == 0);
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            b.illegal = 1; b.regWrite = 0; b.memRead = 0; b.memWrite = 0; b.aluOp = 0;
        end
        return b;
    endfunction

    // Reference pipeline: an in-order queue of at most two decoded bundles.
    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            modelQ.delete();
        end else begin
            modelAccept = inValid && (modelQ.size() < 2);
            if (modelQ.size() > 0 && outReady) void'(modelQ.pop_front());
            if (modelAccept) modelQ.push_back(modelDecode(instr, pc));
        end
    end

    // Every falling edge: handshake state and the visible bundle must match the reference.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (outValid !== (modelQ.size() > 0) || inReady !== (modelQ.size() < 2)) begin
                failures++;
                $display("[TB] FAIL handshake t=%0t actual valid=%b ready=%b required valid=%b ready=%b",
                         $time, outValid, inReady, modelQ.size() > 0, modelQ.size() < 2);
            end
            if (outValid === 1'b1 && modelQ.size() > 0) begin
                checks++;
                if (dutB !== modelQ[0]) begin
                    failures++;
                    $display("[TB] FAIL bundle t=%0t actual=%h required=%h", $time, dutB, modelQ[0]);
                end
            end
            if (outValid === 1'b1 && pcO == 32'hDEAD0000) sawFlushed = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Offer one word from a falling edge and hold it until the stage takes it.
    task automatic applyStimulus(input logic [31:0] w, input logic [31:0] p);
        bit accepted;
        accepted = 1'b0;
        instr = w;
        pc = p;
        inValid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = (inReady === 1'b1);
            @(negedge clk);
        end
        inValid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 0, 1);
    endtask

    initial begin
        #3;
        checkOutput("reset_bundle", dutB, 0);
        checkOutput("reset_valid", outValid, 0);
        checkOutput("reset_ready", inReady, 1);

        checkOutput("model_addi_imm", modelDecode(32'hFFF00093, 0).imm, 32'hFFFFFFFF);
        checkOutput("model_beq_imm", modelDecode(32'hFE000EE3, 0).imm, 32'hFFFFFFFC);
        checkOutput("model_lui_imm", modelDecode(32'h123450B7, 0).imm, 32'h12345000);
        checkOutput("model_sra_alu", modelDecode(32'h4020D133, 0).aluOp, 7);

        @(negedge clk);
        rst = 1'b0;
        outReady = 1'b1;

        applyStimulus(32'hFFF00093, 32'h100);
        checkOutput("t1_valid", outValid, 1);
        checkOutput("t1_rd", rdO, 1);
        checkOutput("t1_imm", immO, 32'hFFFFFFFF);
        checkOutput("t1_alu", aluOpO, 0);
        checkOutput("t1_srcimm", srcImmO, 1);
        checkOutput("t1_rw", regWriteO, 1);

        applyStimulus(32'hFE000EE3, 32'h104);
        checkOutput("t2_imm", immO, 32'hFFFFFFFC);
        checkOutput("t2_branch", branchO, 1);
        checkOutput("t2_alu", aluOpO, 1);
        checkOutput("t2_rw", regWriteO, 0);

        applyStimulus(32'h022081B3, 32'h108);
        checkOutput("t5_muldiv", muldivO, HAS_M);
        checkOutput("t5_illegal", illegalO, !HAS_M);
        checkOutput("t5_rw", regWriteO, HAS_M);

        applyStimulus(32'h00000000, 32'h10C);
        checkOutput("t6_zero_illegal", illegalO, 1);

        for (int i = 0; i < 20; i++) begin
            outReady = (i % 3 != 2);
            applyStimulus(streamVec[i], 32'h200 + 4 * i);
        end
        outReady = 1'b1;
        repeat (4) @(negedge clk);

        outReady = 1'b0;
        applyStimulus(32'h00100093, 32'h300);
        applyStimulus(32'h00200113, 32'h304);
        checkOutput("t3_ready_low", inReady, 0);
        instr = 32'h00300193;
        pc = 32'h308;
        inValid = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("t3_still_full", inReady, 0);
        outReady = 1'b1;
        applyStimulus(32'h00300193, 32'h308);
        repeat (4) @(negedge clk);

        outReady = 1'b0;
        applyStimulus(32'h00400213, 32'h400);
        applyStimulus(32'h00500293, 32'h404);
        flush = 1'b1;
        instr = 32'h00600313;
        pc = 32'hDEAD0000;
        inValid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        inValid = 1'b0;
        checkOutput("t4_valid", outValid, 0);
        checkOutput("t4_ready", inReady, 1);
        outReady = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("t4_flushed_absent", sawFlushed, 0);

        outReady = 1'b0;
        applyStimulus(32'h00700393, 32'h500);
        applyStimulus(32'h00800413, 32'h504);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_valid", outValid, 0);
        checkOutput("t6_async_ready", inReady, 1);
        checkOutput("t6_async_bundle", dutB, 0);
        @(negedge clk);
        rst = 1'b0;
        outReady = 1'b1;
        applyStimulus(32'h00900493, 32'h600);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
